// File: rtl/noc_flit_injector.sv
// rtl/noc_flit_injector.sv - wormhole flit injector with two credit-tracked virtual channels
//
// Turns a local word stream into 68-bit flits for one router input port.
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   src_valid/src_ready    local word handshake; src_data payload, src_last ends packet,
//                          src_vc requested VC (sampled on the head word only)
//   channel_out[0:67]      registered flit: [0] valid, [1] head, [2] tail, [3] vc, [4:67] payload
//   flow_ctrl_in[0:1]      credit return: [0] credit valid, [1] credit VC
//   credits_vc0/vc1        current per-VC credit counts
//   busy                   packet open (state BODY)
//   error                  sticky credit-overflow flag
module noc_flit_injector #(
    parameter int BUFFER_DEPTH = 8,
    parameter int CRED_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [63:0]       src_data,
    input  logic              src_last,
    input  logic              src_vc,
    output logic [0:67]       channel_out,
    input  logic [0:1]        flow_ctrl_in,
    output logic [CRED_W-1:0] credits_vc0,
    output logic [CRED_W-1:0] credits_vc1,
    output logic              busy,
    output logic              error
);

    typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

    localparam logic [CRED_W-1:0] FULL = CRED_W'(BUFFER_DEPTH);

    state_t            state_q, state_d;
    logic              cur_vc_q, cur_vc_d;
    logic [CRED_W-1:0] cred0_q, cred0_d, cred1_q, cred1_d;
    logic              error_q, error_d;
    logic [0:67]       chan_q, chan_d;

    logic vc_use;
    logic accept;
    logic dec0, dec1, inc0, inc1, ovf0, ovf1;

    // The VC is chosen by the head word and then held until the tail.
    assign vc_use    = (state_q == BODY) ? cur_vc_q : src_vc;
    assign src_ready = !reset && (vc_use ? (cred1_q != '0) : (cred0_q != '0));
    assign accept    = src_valid && src_ready;

    assign dec0 = accept && !vc_use;
    assign dec1 = accept && vc_use;
    assign inc0 = flow_ctrl_in[0] && !flow_ctrl_in[1];
    assign inc1 = flow_ctrl_in[0] && flow_ctrl_in[1];

    // A lone increment on a full counter means the router returned more
    // credits than it has buffer slots: hold the count and flag it.
    assign ovf0 = inc0 && !dec0 && (cred0_q == FULL);
    assign ovf1 = inc1 && !dec1 && (cred1_q == FULL);

    function automatic logic [CRED_W-1:0] next_cred(input logic [CRED_W-1:0] c,
                                                    input logic inc, input logic dec);
        logic [CRED_W-1:0] r;
        r = c;
        if (inc && !dec && (c != FULL)) begin
            r = c + CRED_W'(1);
        end else if (dec && !inc) begin
            r = c - CRED_W'(1);
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cur_vc_d = cur_vc_q;
        chan_d   = '0;
        cred0_d  = next_cred(cred0_q, inc0, dec0);
        cred1_d  = next_cred(cred1_q, inc1, dec1);
        error_d  = error_q || ovf0 || ovf1;
        if (accept) begin
            chan_d = {1'b1, (state_q == IDLE), src_last, vc_use, src_data};
            if (state_q == IDLE) begin
                if (!src_last) begin
                    state_d  = BODY;
                    cur_vc_d = src_vc;
                end
            end else if (src_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_vc_q <= 1'b0;
            cred0_q  <= FULL;
            cred1_q  <= FULL;
            error_q  <= 1'b0;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_vc_q <= cur_vc_d;
            cred0_q  <= cred0_d;
            cred1_q  <= cred1_d;
            error_q  <= error_d;
            chan_q   <= chan_d;
        end
    end

    assign channel_out = chan_q;
    assign credits_vc0 = cred0_q;
    assign credits_vc1 = cred1_q;
    assign busy        = (state_q == BODY);
    assign error       = error_q;

endmodule

// File: tb/tb_noc_flit_injector.sv
// tb/tb_noc_flit_injector.sv - self-checking bench for noc_flit_injector
module tb_noc_flit_injector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [63:0] src_data = '0;
    logic        src_last = 1'b0;
    logic        src_vc = 1'b0;
    logic [0:67] channel_out;
    logic [0:1]  flow_ctrl_in = '0;
    logic [3:0]  credits_vc0, credits_vc1;
    logic        busy, error;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet-open flag, held VC, integer credit counts, sticky error.
    int m_cred[2];
    bit m_in_pkt;
    bit m_vc;
    bit m_err;

    noc_flit_injector #(.BUFFER_DEPTH(DEPTH), .CRED_W(4)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_last(src_last), .src_vc(src_vc),
        .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in),
        .credits_vc0(credits_vc0), .credits_vc1(credits_vc1),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("credits_vc0", credits_vc0, m_cred[0]);
        chk("credits_vc1", credits_vc1, m_cred[1]);
        chk("busy", busy, m_in_pkt);
        chk("error", error, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_valid = 1'b1;
        src_last = 1'b0;
        src_vc = 1'b0;
        src_data = 64'h1234;
        flow_ctrl_in = 2'b10;
        #1;
        chk("ready_in_reset", src_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        src_valid = 1'b0;
        flow_ctrl_in = 2'b00;
        m_cred[0] = DEPTH;
        m_cred[1] = DEPTH;
        m_in_pkt = 1'b0;
        m_vc = 1'b0;
        m_err = 1'b0;
        chk("reset_channel", channel_out, 68'h0);
        chk_state();
    endtask

    // One clock of stimulus; checks src_ready before the edge and every output after it.
    task automatic cycle(input logic v, input logic l, input logic vc,
                         input logic [63:0] d, input logic [1:0] fc);
        bit          uvc, acc, hd;
        int          c;
        logic [67:0] ef;
        src_valid = v;
        src_last = l;
        src_vc = vc;
        src_data = d;
        flow_ctrl_in = fc;
        #1;
        uvc = m_in_pkt ? m_vc : vc;
        chk("src_ready", src_ready, m_cred[uvc] > 0);
        acc = v && (m_cred[uvc] > 0);
        hd = !m_in_pkt;
        ef = acc ? {1'b1, hd, l, uvc, d} : 68'h0;
        @(posedge clk); #1;
        if (acc) begin
            if (l) m_in_pkt = 1'b0;
            else if (!m_in_pkt) begin
                m_in_pkt = 1'b1;
                m_vc = vc;
            end
        end
        for (int k = 0; k < 2; k++) begin
            c = m_cred[k];
            if (acc && int'(uvc) == k) c--;
            if (fc[1] && int'(fc[0]) == k) c++;
            if (c > DEPTH) begin
                c = DEPTH;
                m_err = 1'b1;
            end
            m_cred[k] = c;
        end
        chk("channel_out", channel_out, ef);
        chk_state();
        src_valid = 1'b0;
        flow_ctrl_in = 2'b00;
    endtask

    initial begin
        int nflit;
        logic [63:0] rd;

        do_reset();

        // Single-flit packet on VC1.
        cycle(1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 2'b00);
        chk("single_hdr", channel_out[0:3], 4'b1111);
        chk("single_payload", channel_out[4:67], 64'hDEAD_BEEF_0000_0001);
        chk("single_cred1", credits_vc1, 4'd7);
        chk("single_cred0", credits_vc0, 4'd8);
        chk("single_busy", busy, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 2'b11);
        chk("idle_channel_zero", channel_out, 68'h0);

        // Four-word packet on VC0 with src_vc toggling in the body.
        cycle(1'b1, 1'b0, 1'b0, 64'hA0, 2'b00);
        chk("pkt4_f0", channel_out[0:3], 4'b1100);
        chk("pkt4_busy0", busy, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 64'hA1, 2'b00);
        chk("pkt4_f1", channel_out[0:3], 4'b1000);
        cycle(1'b1, 1'b0, 1'b0, 64'hA2, 2'b00);
        chk("pkt4_f2", channel_out[0:3], 4'b1000);
        chk("pkt4_busy2", busy, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 64'hA3, 2'b00);
        chk("pkt4_f3", channel_out[0:3], 4'b1010);
        chk("pkt4_busy3", busy, 1'b0);
        chk("pkt4_cred0", credits_vc0, 4'd4);

        // Credit exhaustion on VC0.
        do_reset();
        nflit = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 64'(i), 2'b00);
            nflit += int'(channel_out[0]);
        end
        chk("exhaust_flits", nflit, 8);
        src_valid = 1'b1;
        #1;
        chk("exhaust_ready_low", src_ready, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h55, 2'b10);
        chk("exhaust_no_flit", channel_out[0], 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 64'h66, 2'b00);
        chk("exhaust_one_more", channel_out[0:3], 4'b1010);

        // Simultaneous decrement and increment.
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 64'h10, 2'b00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 64'(i), 2'b00);
        chk("sim_pre_cred0", credits_vc0, 4'd5);
        cycle(1'b1, 1'b1, 1'b0, 64'h20, 2'b10);
        chk("sim_same_vc", credits_vc0, 4'd5);
        cycle(1'b1, 1'b1, 1'b0, 64'h21, 2'b11);
        chk("sim_other_cred0", credits_vc0, 4'd4);
        chk("sim_other_cred1", credits_vc1, 4'd8);

        // Overflow on a full VC1.
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 2'b11);
        chk("ovf_error", error, 1'b1);
        chk("ovf_cred1", credits_vc1, 4'd8);
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 2'b00);
        chk("ovf_sticky", error, 1'b1);

        // Reset mid-packet.
        cycle(1'b1, 1'b0, 1'b1, 64'h30, 2'b00);
        cycle(1'b1, 1'b0, 1'b0, 64'h31, 2'b00);
        do_reset();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_error", error, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h40, 2'b00);
        chk("midrst_head", channel_out[1], 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom};
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), rd,
                  {($urandom_range(0, 2) == 0), 1'($urandom)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
